// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, IV, register offsets, FSM states and round functions
package sha256_pkg;
  localparam logic [4:0] OFF_H = 5'h10;
  localparam logic [4:0] OFF_CTRL = 5'h18;
  localparam logic [4:0] OFF_STATUS = 5'h19;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; vin/vout hold a..h at indices 0..7, k/w are the round constant and word
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] vin,
  input  logic [31:0]      k,
  input  logic [31:0]      w,
  output logic [7:0][31:0] vout
);
  logic [31:0] t1, t2;
  always_comb begin
    t1 = vin[7] + bsig1(vin[4]) + ch(vin[4], vin[5], vin[6]) + k + w;
    t2 = bsig0(vin[0]) + maj(vin[0], vin[1], vin[2]);
    vout = {vin[6:4], vin[3] + t1, vin[2:0], t1 + t2};
  end
endmodule

// File: rtl/sha256_accel.sv
// sha256_accel: CPU-mapped SHA-256 compressor (accel_* bus in, accel_rd_data/busy/done_pulse out; SHA256_DOUBLE_EN enables double-SHA)
module sha256_accel
  import sha256_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'hFF00
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] accel_addr,
  input  logic                  accel_wrt_en,
  input  logic [31:0]           accel_wrt_data,
  input  logic                  accel_rd_en,
  output logic [31:0]           accel_rd_data,
  output logic                  busy,
  output logic                  done_pulse
);
  state_t state, state_d;
  logic [15:0][31:0] w_reg, sched, blk2;
  logic [7:0][31:0] h_reg, wv, rnd, digest;
  logic [5:0] cnt;
  logic [4:0] off;
  logic [31:0] new_w, rd_mux;
  logic done, err, sel, wr_ok, wr_bad, start, dbl;
  assign busy = state != S_IDLE;
  assign done_pulse = state == S_FINAL && !dbl;
  always_comb begin
    sel = accel_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];
    off = accel_addr[4:0];
    wr_ok = accel_wrt_en && sel && !busy;
    wr_bad = accel_wrt_en && sel && busy && off <= OFF_CTRL;
    start = wr_ok && off == OFF_CTRL && accel_wrt_data[0];
    new_w = ssig1(sched[14]) + sched[9] + ssig0(sched[1]) + sched[0];
    for (int i = 0; i < 8; i++) digest[i] = h_reg[i] + wv[i];
    blk2 = {32'h00000100, 192'h0, 32'h80000000, digest};
    rd_mux = off < OFF_H ? w_reg[off[3:0]] :
             off < OFF_CTRL ? h_reg[off[2:0]] :
             off == OFF_STATUS ? {29'h0, err, done, busy} : 32'h0;
  end
  always_comb begin
    state_d = state == S_IDLE ? (start ? S_ROUND : S_IDLE) :
              state == S_ROUND ? (cnt == 6'd63 ? S_FINAL : S_ROUND) :
              dbl ? S_ROUND : S_IDLE;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_d;
`ifdef SHA256_DOUBLE_EN
  always_ff @(posedge clk)
    if (rst) dbl <= 1'b0;
    else if (start) dbl <= accel_wrt_data[1];
    else if (state == S_FINAL) dbl <= 1'b0;
`else
  assign dbl = 1'b0;
`endif
  sha256_round u_round (.vin(wv), .k(K[cnt]), .w(sched[0]), .vout(rnd));
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg <= '0;
      h_reg <= '0;
      wv <= '0;
      sched <= '0;
      cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
      accel_rd_data <= '0;
    end else begin
      if (accel_rd_en && sel) accel_rd_data <= rd_mux;
      if (wr_ok && off < OFF_H) w_reg[off[3:0]] <= accel_wrt_data;
      if (wr_ok && off >= OFF_H && off < OFF_CTRL) h_reg[off[2:0]] <= accel_wrt_data;
      if (wr_bad) err <= 1'b1;
      if (start) begin
        wv <= h_reg;
        sched <= w_reg;
        cnt <= '0;
        done <= 1'b0;
        err <= 1'b0;
      end
      if (state == S_ROUND) begin
        wv <= rnd;
        sched <= {new_w, sched[15:1]};
        cnt <= cnt + 6'd1;
      end
      if (state == S_FINAL && dbl) begin
        w_reg <= blk2;
        sched <= blk2;
        h_reg <= IV;
        wv <= IV;
      end else if (state == S_FINAL) begin
        h_reg <= digest;
        done <= 1'b1;
      end
    end
  end
endmodule
